calc_controller: RTL and testbench
==================================

// Module: calc_controller
// PURPOSE
// Sequencing FSM for the hex calculator. It sits between the keypad scanner and the
// Registers/ALU datapath. Each keypad event becomes one-cycle newhex/newop/eq/BS strobes
// to Registers. It latches the pending operator, runs the multi-cycle ALU through a
// start/done handshake, and enforces operand-length and timeout rules.
// PARAMETERS
// MAX_DIGITS    4    max hex digits accepted per operand; extra digits are dropped
// CALC_TIMEOUT  64   cycles to wait for alu_done before flagging err
// PORTS
// clock      in   1  system clock, all logic on rising edge
// reset      in   1  synchronous, active-high; overrides all other inputs
// keyvalid   in   1  one-cycle pulse: keycode is valid this cycle
// keycode    in   5  0x00-0x0F digit, 0x10 ADD, 0x11 SUB, 0x12 MUL, 0x13 EQ, 0x14 BS, 0x15 CLR, others ignored
// alu_done   in   1  one-cycle pulse: ALU answer is valid on the Registers answer bus
// newhex     out  1  strobe: shift hexcode into the active operand
// hexcode    out  4  digit value; valid while newhex=1, otherwise 0
// newop      out  1  strobe: V1 complete, start V2 entry
// eq         out  1  strobe: load answer into V1
// BS         out  1  strobe: delete last digit of the active operand
// regclr     out  1  strobe: clear both operand registers
// alu_start  out  1  strobe: begin ALU operation on V1, V2
// alu_op     out  2  latched operator: 00 ADD, 01 SUB, 10 MUL; held stable through CALC
// busy       out  1  1 while in CALC
// err        out  1  sticky timeout flag; cleared by CLR, reset or the next alu_start
// BEHAVIOUR
// - Reset: state=ENTER_V1, digit count=0, all outputs 0, alu_op=00.
// - All outputs are registered. A strobe asserts the cycle after keyvalid is sampled
//   and lasts exactly one cycle. At most one Registers strobe is asserted in any cycle.
// - States: ENTER_V1, OP_WAIT, ENTER_V2, CALC, RESULT.
// - ENTER_V1 / ENTER_V2:
//   - digit: if cnt<MAX_DIGITS, pulse newhex and cnt++; otherwise drop the digit.
//   - BS: if cnt>0, pulse BS and cnt--; otherwise drop it.
//   - EQ in ENTER_V1: ignored.
// - ENTER_V1 + operator: latch alu_op, pulse newop, cnt=0, go to OP_WAIT.
// - OP_WAIT:
//   - digit: newhex, cnt=1, go to ENTER_V2.
//   - operator: replace alu_op only; no strobe.
//   - BS and EQ: ignored.
// - ENTER_V2 + EQ: pulse alu_start, clear err, go to CALC (chain=0).
// - ENTER_V2 + operator: alu_start, store the new op in next_op, chain=1, go to CALC.
// - CALC: busy=1. Every key except CLR is dropped.
//   - alu_done: pulse eq.
//   - chain=0: go to RESULT.
//   - chain=1: next cycle alu_op<=next_op and pulse newop, cnt=0, go to OP_WAIT.
// - CALC timeout: the counter starts at alu_start. After CALC_TIMEOUT cycles without
//   alu_done: set err, no eq strobe, go to RESULT. A later stray alu_done is ignored.
// - RESULT:
//   - operator: latch alu_op, pulse newop, go to OP_WAIT (the answer becomes V1).
//   - digit: pulse regclr, then newhex on the following cycle from a one-deep held
//     digit, cnt=1, go to ENTER_V1. A key arriving in the gap cycle is dropped.
//   - BS and EQ: ignored.
// - CLR in any state, including CALC: pulse regclr, cnt=0, err=0, chain=0, go to
//   ENTER_V1. The in-flight alu_done is ignored.
// - keyvalid and alu_done in the same CALC cycle: alu_done is processed, the key dropped.
// - Reset asserted mid-operation (for example in CALC): return to the reset state on
//   the next edge; no strobes on that edge.
// - Undefined keycodes (0x16-0x1F): no effect in any state.
// STRUCTURE
// - calc_pkg holds: keycode constants, ALU op encoding (2-bit), FSM state encoding,
//   and the default MAX_DIGITS.
// - Sub-module calc_key_decode (combinational): keycode -> is_digit, is_op, is_eq,
//   is_bs, is_clr, op_code. Everything else lives in calc_controller.
// TESTING
// - Reset for 2 cycles, then key 3, key 2 -> two newhex pulses, hexcode 3 then 2;
//   state ENTER_V1, cnt=2.
// - Keys 1,2,3,4,5 -> exactly four newhex pulses; then BS x5 -> exactly four BS pulses.
// - 3, ADD, SUB, 1, EQ -> newop once, alu_op=01 at alu_start; alu_done after 5 cycles
//   -> one eq pulse, state RESULT.
// - 5, ADD, 2, MUL -> alu_start with op 00; on alu_done: eq, then newop next cycle,
//   alu_op=10, state OP_WAIT.
// - 1, ADD, 1, EQ, alu_done withheld 64 cycles -> err=1, no eq, state RESULT; then
//   digit 7 -> regclr, then newhex hexcode 7 next cycle, err cleared by next alu_start.
// - CLR during CALC -> regclr, ENTER_V1, busy=0; alu_done 3 cycles later -> no eq;
//   reset asserted in OP_WAIT -> all outputs 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the hex calculator controller: keycodes, ALU op encoding,
// FSM state encoding and default sizing.
package calc_pkg;

  localparam int MAX_DIGITS_DEF   = 4;
  localparam int CALC_TIMEOUT_DEF = 64;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_SUB = 5'h11;
  localparam logic [4:0] KEY_MUL = 5'h12;
  localparam logic [4:0] KEY_EQ  = 5'h13;
  localparam logic [4:0] KEY_BS  = 5'h14;
  localparam logic [4:0] KEY_CLR = 5'h15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  // ST_CHAIN and ST_LOAD are the one-cycle gaps that keep Registers strobes apart.
  typedef enum logic [2:0] {
    ST_ENTER_V1 = 3'd0,
    ST_OP_WAIT  = 3'd1,
    ST_ENTER_V2 = 3'd2,
    ST_CALC     = 3'd3,
    ST_RESULT   = 3'd4,
    ST_CHAIN    = 3'd5,
    ST_LOAD     = 3'd6
  } state_t;

endpackage

// File: rtl/calc_key_decode.sv
// Combinational keycode classifier; undefined codes (0x16-0x1F) assert nothing.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic [4:0] i_keycode,
  output logic       o_is_digit,
  output logic       o_is_op,
  output logic       o_is_eq,
  output logic       o_is_bs,
  output logic       o_is_clr,
  output logic [1:0] o_op_code
);

  always_comb begin
    o_is_digit = ~i_keycode[4];
    o_is_op    = (i_keycode == KEY_ADD) || (i_keycode == KEY_SUB) || (i_keycode == KEY_MUL);
    o_is_eq    = (i_keycode == KEY_EQ);
    o_is_bs    = (i_keycode == KEY_BS);
    o_is_clr   = (i_keycode == KEY_CLR);
    o_op_code  = o_is_op ? i_keycode[1:0] : OP_ADD;
  end

endmodule

// File: rtl/calc_controller.sv
// Sequencing FSM between keypad scanner and Registers/ALU datapath.
// All outputs are registered; strobes are one cycle wide and mutually exclusive.
module calc_controller
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS   = MAX_DIGITS_DEF,
  parameter int CALC_TIMEOUT = CALC_TIMEOUT_DEF
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_keyvalid,
  input  logic [4:0]                        i_keycode,
  input  logic                              i_alu_done,
  output logic                              o_newhex,
  output logic [3:0]                        o_hexcode,
  output logic                              o_newop,
  output logic                              o_eq,
  output logic                              o_bs,
  output logic                              o_regclr,
  output logic                              o_alu_start,
  output logic [1:0]                        o_alu_op,
  output logic                              o_busy,
  output logic                              o_err,
  output logic [2:0]                        o_state,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   o_digit_cnt
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TMR_W = $clog2(CALC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CALC_TIMEOUT);

  logic       w_is_digit, w_is_op, w_is_eq, w_is_bs, w_is_clr;
  logic [1:0] w_op_code;

  calc_key_decode u_key_decode (
    .i_keycode (i_keycode),
    .o_is_digit(w_is_digit),
    .o_is_op   (w_is_op),
    .o_is_eq   (w_is_eq),
    .o_is_bs   (w_is_bs),
    .o_is_clr  (w_is_clr),
    .o_op_code (w_op_code)
  );

  logic w_key_digit, w_key_op, w_key_eq, w_key_bs, w_key_clr;
  assign w_key_digit = i_keyvalid & w_is_digit;
  assign w_key_op    = i_keyvalid & w_is_op;
  assign w_key_eq    = i_keyvalid & w_is_eq;
  assign w_key_bs    = i_keyvalid & w_is_bs;
  assign w_key_clr   = i_keyvalid & w_is_clr;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [1:0]       r_alu_op, w_alu_op_nxt;
  logic [1:0]       r_next_op, w_next_op_nxt;
  logic             r_chain, w_chain_nxt;
  logic             r_err, w_err_nxt;
  logic [3:0]       r_held, w_held_nxt;

  logic       w_newhex_nxt, w_newop_nxt, w_eq_nxt, w_bs_nxt, w_regclr_nxt;
  logic       w_start_nxt, w_busy_nxt;
  logic [3:0] w_hexcode_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timer_nxt   = r_timer;
    w_alu_op_nxt  = r_alu_op;
    w_next_op_nxt = r_next_op;
    w_chain_nxt   = r_chain;
    w_err_nxt     = r_err;
    w_held_nxt    = r_held;
    w_newhex_nxt  = 1'b0;
    w_hexcode_nxt = 4'h0;
    w_newop_nxt   = 1'b0;
    w_eq_nxt      = 1'b0;
    w_bs_nxt      = 1'b0;
    w_regclr_nxt  = 1'b0;
    w_start_nxt   = 1'b0;

    if (w_key_clr) begin
      w_regclr_nxt = 1'b1;
      w_cnt_nxt    = '0;
      w_err_nxt    = 1'b0;
      w_chain_nxt  = 1'b0;
      w_state_nxt  = ST_ENTER_V1;
    end else begin
      unique case (r_state)
        ST_ENTER_V1, ST_ENTER_V2: begin
          if (w_key_digit) begin
            if (r_cnt < MAX_CNT) begin
              w_newhex_nxt  = 1'b1;
              w_hexcode_nxt = i_keycode[3:0];
              w_cnt_nxt     = r_cnt + 1'b1;
            end
          end else if (w_key_bs) begin
            if (r_cnt != '0) begin
              w_bs_nxt  = 1'b1;
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end else if (w_key_op && r_state == ST_ENTER_V1) begin
            w_alu_op_nxt = w_op_code;
            w_newop_nxt  = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = ST_OP_WAIT;
          end else if ((w_key_op || w_key_eq) && r_state == ST_ENTER_V2) begin
            // An operator here both evaluates and queues itself for the chained op.
            w_start_nxt   = 1'b1;
            w_err_nxt     = 1'b0;
            w_timer_nxt   = TMR_LOAD;
            w_chain_nxt   = w_key_op;
            w_next_op_nxt = w_key_op ? w_op_code : r_next_op;
            w_state_nxt   = ST_CALC;
          end
        end
        ST_OP_WAIT: begin
          if (w_key_digit) begin
            w_newhex_nxt  = 1'b1;
            w_hexcode_nxt = i_keycode[3:0];
            w_cnt_nxt     = CNT_W'(1);
            w_state_nxt   = ST_ENTER_V2;
          end else if (w_key_op) begin
            w_alu_op_nxt = w_op_code;
          end
        end
        ST_CALC: begin
          if (i_alu_done) begin
            w_eq_nxt    = 1'b1;
            w_state_nxt = r_chain ? ST_CHAIN : ST_RESULT;
          end else if (r_timer <= TMR_W'(1)) begin
            w_err_nxt   = 1'b1;
            w_chain_nxt = 1'b0;
            w_state_nxt = ST_RESULT;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        ST_CHAIN: begin
          w_alu_op_nxt = r_next_op;
          w_newop_nxt  = 1'b1;
          w_cnt_nxt    = '0;
          w_chain_nxt  = 1'b0;
          w_state_nxt  = ST_OP_WAIT;
        end
        ST_RESULT: begin
          if (w_key_op) begin
            w_alu_op_nxt = w_op_code;
            w_newop_nxt  = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = ST_OP_WAIT;
          end else if (w_key_digit) begin
            w_regclr_nxt = 1'b1;
            w_held_nxt   = i_keycode[3:0];
            w_state_nxt  = ST_LOAD;
          end
        end
        ST_LOAD: begin
          w_newhex_nxt  = 1'b1;
          w_hexcode_nxt = r_held;
          w_cnt_nxt     = CNT_W'(1);
          w_state_nxt   = ST_ENTER_V1;
        end
        default: begin
          w_state_nxt = ST_ENTER_V1;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == ST_CALC);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_ENTER_V1;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_alu_op    <= OP_ADD;
      r_next_op   <= OP_ADD;
      r_chain     <= 1'b0;
      r_err       <= 1'b0;
      r_held      <= 4'h0;
      o_newhex    <= 1'b0;
      o_hexcode   <= 4'h0;
      o_newop     <= 1'b0;
      o_eq        <= 1'b0;
      o_bs        <= 1'b0;
      o_regclr    <= 1'b0;
      o_alu_start <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_timer     <= w_timer_nxt;
      r_alu_op    <= w_alu_op_nxt;
      r_next_op   <= w_next_op_nxt;
      r_chain     <= w_chain_nxt;
      r_err       <= w_err_nxt;
      r_held      <= w_held_nxt;
      o_newhex    <= w_newhex_nxt;
      o_hexcode   <= w_hexcode_nxt;
      o_newop     <= w_newop_nxt;
      o_eq        <= w_eq_nxt;
      o_bs        <= w_bs_nxt;
      o_regclr    <= w_regclr_nxt;
      o_alu_start <= w_start_nxt;
      o_busy      <= w_busy_nxt;
    end
  end

  assign o_alu_op    = r_alu_op;
  assign o_err       = r_err;
  assign o_state     = r_state;
  assign o_digit_cnt = r_cnt;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: hand-computed expectations checked with
// immediate assertions after each key event.
module tb_calc_controller;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_keyvalid = 1'b0;
  logic [4:0] i_keycode = 5'h00;
  logic       i_alu_done = 1'b0;
  logic       o_newhex, o_newop, o_eq, o_bs, o_regclr, o_alu_start, o_busy, o_err;
  logic [3:0] o_hexcode;
  logic [1:0] o_alu_op;
  logic [2:0] o_state;
  logic [2:0] o_digit_cnt;

  localparam logic [2:0] S_V1 = 3'd0, S_OPW = 3'd1, S_V2 = 3'd2, S_CALC = 3'd3,
                         S_RES = 3'd4, S_CHAIN = 3'd5, S_LOAD = 3'd6;
  localparam logic [4:0] K_ADD = 5'h10, K_SUB = 5'h11, K_MUL = 5'h12,
                         K_EQ = 5'h13, K_BS = 5'h14, K_CLR = 5'h15;

  int n_checks = 0;
  int n_errors = 0;

  calc_controller dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_keyvalid (i_keyvalid),
    .i_keycode  (i_keycode),
    .i_alu_done (i_alu_done),
    .o_newhex   (o_newhex),
    .o_hexcode  (o_hexcode),
    .o_newop    (o_newop),
    .o_eq       (o_eq),
    .o_bs       (o_bs),
    .o_regclr   (o_regclr),
    .o_alu_start(o_alu_start),
    .o_alu_op   (o_alu_op),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .o_state    (o_state),
    .o_digit_cnt(o_digit_cnt)
  );

  always #5 clk = ~clk;

  logic [14:0] w_outs;
  assign w_outs = {o_newhex, o_hexcode, o_newop, o_eq, o_bs, o_regclr,
                   o_alu_start, o_alu_op, o_busy, o_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one key for one cycle; on return the resulting strobes are visible.
  task automatic key(input logic [4:0] code);
    @(negedge clk);
    i_keyvalid = 1'b1;
    i_keycode  = code;
    @(negedge clk);
    i_keyvalid = 1'b0;
    i_keycode  = 5'h00;
  endtask

  task automatic done_pulse();
    @(negedge clk);
    i_alu_done = 1'b1;
    @(negedge clk);
    i_alu_done = 1'b0;
  endtask

  initial begin
    int nh, nb, ne;

    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(w_outs), 32'h0);
    chk("reset_state", 32'(o_state), 32'(S_V1));
    chk("reset_cnt", 32'(o_digit_cnt), 32'h0);
    i_reset = 1'b0;

    key(5'h03);
    chk("d3_newhex", 32'(o_newhex), 32'h1);
    chk("d3_hexcode", 32'(o_hexcode), 32'h3);
    key(5'h02);
    chk("d2_hexcode", 32'(o_hexcode), 32'h2);
    chk("d2_state", 32'(o_state), 32'(S_V1));
    chk("d2_cnt", 32'(o_digit_cnt), 32'h2);
    @(negedge clk);
    chk("strobe_one_cycle", 32'({o_newhex, o_hexcode}), 32'h0);
    key(K_EQ);
    chk("eq_in_v1_ignored", 32'({o_alu_start, o_state}), 32'(S_V1));

    // Digit limit and backspace underflow
    key(K_CLR);
    chk("clr_regclr", 32'(o_regclr), 32'h1);
    chk("clr_cnt", 32'(o_digit_cnt), 32'h0);
    nh = 0;
    for (int k = 1; k <= 5; k++) begin
      key(5'(k));
      nh += int'(o_newhex);
    end
    chk("max_digits_newhex", 32'(nh), 32'd4);
    chk("max_digits_cnt", 32'(o_digit_cnt), 32'd4);
    nb = 0;
    for (int k = 0; k < 5; k++) begin
      key(K_BS);
      nb += int'(o_bs);
    end
    chk("bs_count", 32'(nb), 32'd4);
    chk("bs_cnt", 32'(o_digit_cnt), 32'd0);

    // 3 ADD SUB 1 EQ, done after 5 cycles
    key(5'h03);
    key(K_ADD);
    chk("add_newop", 32'(o_newop), 32'h1);
    chk("add_state", 32'(o_state), 32'(S_OPW));
    key(K_SUB);
    chk("sub_replace_nostrobe", 32'({o_newop, o_newhex, o_regclr}), 32'h0);
    chk("sub_replace_op", 32'(o_alu_op), 32'h1);
    key(5'h01);
    chk("v2_newhex", 32'({o_newhex, o_hexcode}), 32'h11);
    chk("v2_state", 32'(o_state), 32'(S_V2));
    key(K_EQ);
    chk("eq_start", 32'({o_alu_start, o_busy, o_alu_op}), 32'b1101);
    chk("eq_state", 32'(o_state), 32'(S_CALC));
    repeat (3) @(negedge clk);
    done_pulse();
    chk("done_eq", 32'(o_eq), 32'h1);
    chk("done_state", 32'(o_state), 32'(S_RES));
    chk("done_busy", 32'(o_busy), 32'h0);
    @(negedge clk);
    chk("eq_one_cycle", 32'(o_eq), 32'h0);

    // Digit in RESULT: regclr, then held digit
    key(5'h05);
    chk("res_digit_regclr", 32'({o_regclr, o_newhex}), 32'b10);
    chk("res_digit_gap", 32'(o_state), 32'(S_LOAD));
    @(negedge clk);
    chk("res_digit_newhex", 32'({o_newhex, o_hexcode, o_regclr}), 32'b1_0101_0);
    chk("res_digit_state", 32'(o_state), 32'(S_V1));
    chk("res_digit_cnt", 32'(o_digit_cnt), 32'h1);

    // 5 ADD 2 MUL chain
    key(K_ADD);
    chk("chain_add_op", 32'({o_newop, o_alu_op}), 32'b100);
    key(5'h02);
    key(K_MUL);
    chk("chain_start", 32'({o_alu_start, o_alu_op}), 32'b100);
    repeat (2) @(negedge clk);
    chk("chain_op_held", 32'(o_alu_op), 32'h0);
    done_pulse();
    chk("chain_eq", 32'({o_eq, o_newop, o_alu_op}), 32'b1000);
    chk("chain_gap_state", 32'(o_state), 32'(S_CHAIN));
    @(negedge clk);
    chk("chain_newop", 32'({o_eq, o_newop, o_alu_op}), 32'b0110);
    chk("chain_state", 32'(o_state), 32'(S_OPW));
    chk("chain_cnt", 32'(o_digit_cnt), 32'h0);

    // Timeout
    key(K_CLR);
    key(5'h01);
    key(K_ADD);
    key(5'h01);
    key(K_EQ);
    chk("to_start", 32'({o_alu_start, o_err}), 32'b10);
    ne = 0;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      ne += int'(o_eq);
    end
    chk("to_edge_minus1", 32'({o_busy, o_err, o_state}), 32'({2'b10, S_CALC}));
    @(negedge clk);
    ne += int'(o_eq);
    chk("to_err", 32'(o_err), 32'h1);
    chk("to_state", 32'(o_state), 32'(S_RES));
    chk("to_no_eq", 32'(ne), 32'd0);
    done_pulse();
    chk("stray_done", 32'({o_eq, o_state}), 32'(S_RES));
    key(5'h07);
    chk("to_digit_regclr", 32'({o_regclr, o_err}), 32'b11);
    @(negedge clk);
    chk("to_digit_newhex", 32'({o_newhex, o_hexcode}), 32'h17);
    key(K_ADD);
    key(5'h01);
    chk("err_sticky", 32'(o_err), 32'h1);
    key(K_EQ);
    chk("err_cleared_by_start", 32'({o_alu_start, o_err}), 32'b10);

    // CLR during CALC, late done ignored
    repeat (2) @(negedge clk);
    key(K_CLR);
    chk("clr_calc", 32'({o_regclr, o_busy, o_state}), 32'({2'b10, S_V1}));
    @(negedge clk);
    done_pulse();
    chk("clr_late_done", 32'({o_eq, o_state}), 32'(S_V1));

    // Key and alu_done together in CALC
    key(5'h01);
    key(K_ADD);
    key(5'h02);
    key(K_EQ);
    @(negedge clk);
    i_keyvalid = 1'b1;
    i_keycode  = 5'h03;
    i_alu_done = 1'b1;
    @(negedge clk);
    i_keyvalid = 1'b0;
    i_keycode  = 5'h00;
    i_alu_done = 1'b0;
    chk("key_done_same", 32'({o_eq, o_newhex}), 32'b10);
    chk("key_done_state", 32'(o_state), 32'(S_RES));

    key(5'h16);
    chk("undef_key", 32'(w_outs), 32'h0);
    chk("undef_state", 32'(o_state), 32'(S_RES));

    // Reset in OP_WAIT with a key pending
    key(K_ADD);
    key(K_MUL);
    chk("pre_reset_op", 32'({o_alu_op, o_state}), 32'({2'b10, S_OPW}));
    @(negedge clk);
    i_reset    = 1'b1;
    i_keyvalid = 1'b1;
    i_keycode  = 5'h04;
    @(negedge clk);
    i_keyvalid = 1'b0;
    i_keycode  = 5'h00;
    chk("mid_reset_outs", 32'(w_outs), 32'h0);
    chk("mid_reset_state", 32'(o_state), 32'(S_V1));
    i_reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
